div_iter: RTL and testbench

Iterative 32-bit radix-2 restoring divider serving the EX stage's DIV/DIVU path. The divider accepts operands and a start request from the EX stage. It computes the quotient and remainder over multiple cycles and returns a 64-bit `{remainder, quotient}` word with a ready flag. The EX stage writes that word to HI/LO. While a division is in flight, EX holds `start_i` high and stalls the pipeline. A flush from the exception/branch path annuls the operation.

---
 rtl/div_iter.sv | 127 ++++++++++++
 tb/tb_div_iter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/div_iter.sv
// Iterative 32-bit radix-2 restoring divider for the EX stage DIV/DIVU path.
// Optional DIV_LZC_EN: skip the dividend's leading zeros to shorten latency.
module div_iter (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {S_IDLE, S_BYZERO, S_ON, S_END} state_t;

  state_t      state;
  logic [64:0] work;
  logic [31:0] divisor;
  logic [5:0]  cnt;
  logic [5:0]  n_iter;
  logic        neg_quo;
  logic        neg_rem;

  logic [31:0] abs_a, abs_b, pre_a;
  logic [5:0]  n_acc;

  assign abs_a = (signed_div_i && opdata1_i[31]) ? -opdata1_i : opdata1_i;
  assign abs_b = (signed_div_i && opdata2_i[31]) ? -opdata2_i : opdata2_i;

`ifdef DIV_LZC_EN
  function automatic logic [5:0] lzc(input logic [31:0] v);
    lzc = 6'd32;
    for (int i = 0; i < 32; i++)
      if (v[i]) lzc = 6'(31 - i);
  endfunction

  logic [5:0] lz;
  assign lz    = lzc(abs_a);
  assign pre_a = abs_a << lz;
  // Zero dividend still runs one iteration so the END path stays uniform.
  assign n_acc = (lz == 6'd32) ? 6'd1 : 6'd32 - lz;
`else
  assign pre_a = abs_a;
  assign n_acc = 6'd32;
`endif

  // One restoring step: shift, trial-subtract, keep on non-negative.
  logic [64:0] shifted;
  logic [32:0] trial;
  logic [64:0] work_nxt;
  logic [31:0] quo_fin, rem_fin;

  assign shifted  = work << 1;
  assign trial    = shifted[64:32] - {1'b0, divisor};
  assign work_nxt = trial[32] ? shifted : {trial, shifted[31:1], 1'b1};
  assign quo_fin  = neg_quo ? -work_nxt[31:0]  : work_nxt[31:0];
  assign rem_fin  = neg_rem ? -work_nxt[63:32] : work_nxt[63:32];

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      work     <= '0;
      divisor  <= '0;
      cnt      <= '0;
      n_iter   <= '0;
      neg_quo  <= 1'b0;
      neg_rem  <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          result_o <= '0;
          ready_o  <= 1'b0;
          if (start_i && !annul_i) begin
            if (opdata2_i == 32'd0) begin
              state <= S_BYZERO;
            end else begin
              work    <= {33'd0, pre_a};
              divisor <= abs_b;
              n_iter  <= n_acc;
              neg_quo <= signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
              neg_rem <= signed_div_i && opdata1_i[31];
              cnt     <= '0;
              state   <= S_ON;
            end
          end
        end
        S_BYZERO: begin
          work <= '0;
          if (annul_i) begin
            state <= S_IDLE;
          end else begin
            result_o <= '0;
            ready_o  <= 1'b1;
            state    <= S_END;
          end
        end
        S_ON: begin
          if (annul_i) begin
            state    <= S_IDLE;
            result_o <= '0;
            ready_o  <= 1'b0;
          end else begin
            work <= work_nxt;
            cnt  <= cnt + 6'd1;
            if (cnt == n_iter - 6'd1) begin
              result_o <= {rem_fin, quo_fin};
              ready_o  <= 1'b1;
              state    <= S_END;
            end
          end
        end
        S_END: begin
          if (!start_i || annul_i) begin
            state    <= S_IDLE;
            result_o <= '0;
            ready_o  <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: directed cases plus random operands vs an arithmetic model.
module tb_div_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i, opdata2_i;
  logic        start_i, annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int errors = 0;
  int checks = 0;

  div_iter dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model_res(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [31:0] q32, r32;
    if (b == 32'd0) return 64'd0;
    if (!s) return {a % b, a / b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q = sa / sb;
    r = sa % sb;
    q32 = q[31:0];
    r32 = r[31:0];
    return {r32, q32};
  endfunction

  function automatic int model_lat(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] mag;
    int n;
    if (b == 32'd0) return 2;
    mag = (s && a[31]) ? (32'd0 - a) : a;
`ifdef DIV_LZC_EN
    n = 1;
    for (int i = 0; i < 32; i++)
      if ((mag >> i) != 32'd0) n = i + 1;
`else
    n = 32 + (mag == mag ? 0 : 1);
`endif
    return n + 1;
  endfunction

  task automatic do_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] exp_res;
    int exp_lat, lat;
    bit early_bad;
    exp_res = model_res(s, a, b);
    exp_lat = model_lat(s, a, b);
    @(negedge clk);
    signed_div_i = s; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
    @(posedge clk); #1;
    signed_div_i = 1'($urandom); opdata1_i = $urandom; opdata2_i = $urandom;
    lat = 1; early_bad = 0;
    while (ready_o !== 1'b1 && lat < 40) begin
      if (result_o !== 64'd0 || ready_o !== 1'b0) early_bad = 1;
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat !== exp_lat) begin
      errors++; $display("FAIL latency s=%0d %h/%h: got %0d want %0d", s, a, b, lat, exp_lat);
    end
    checks++;
    if (early_bad) begin
      errors++; $display("FAIL pre_ready_zero s=%0d %h/%h: outputs nonzero before ready", s, a, b);
    end
    checks++;
    if (result_o !== exp_res) begin
      errors++; $display("FAIL result s=%0d %h/%h: got %h want %h", s, a, b, result_o, exp_res);
    end
    @(posedge clk); #1;
    checks++;
    if (ready_o !== 1'b1 || result_o !== exp_res) begin
      errors++; $display("FAIL hold s=%0d %h/%h: ready=%b result=%h want 1 %h", s, a, b, ready_o, result_o, exp_res);
    end
    @(negedge clk); start_i = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      errors++; $display("FAIL drop ready=%b result=%h want 0 0", ready_o, result_o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", ready_o); end
    checks++;
    if (result_o !== 64'd0) begin errors++; $display("FAIL reset_result got %h want 0", result_o); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_directed();
    do_div(1'b0, 32'd100, 32'd7);
    do_div(1'b1, 32'hFFFFFFF9, 32'h00000002);
    do_div(1'b0, 32'hFFFFFFF9, 32'h00000002);
    do_div(1'b0, 32'd5, 32'd0);
    do_div(1'b1, 32'h80000000, 32'hFFFFFFFF);
    do_div(1'b1, 32'h00000000, 32'h00000005);
    do_div(1'b1, 32'h7FFFFFFF, 32'h80000000);
    do_div(1'b0, 32'hFFFFFFFF, 32'h00000001);
  endtask

  task automatic test_annul();
    bit rose;
    rose = 0;
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'hF0000000; opdata2_i = 32'd7; start_i = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c < 10; c++) begin
      if (ready_o !== 1'b0) rose = 1;
      @(posedge clk); #1;
    end
    if (ready_o !== 1'b0) rose = 1;
    @(negedge clk); annul_i = 1'b1; start_i = 1'b0;
    @(posedge clk); #1;
    if (ready_o !== 1'b0 || result_o !== 64'd0) rose = 1;
    @(negedge clk); annul_i = 1'b0;
    @(posedge clk); #1;
    if (ready_o !== 1'b0 || result_o !== 64'd0) rose = 1;
    checks++;
    if (rose) begin errors++; $display("FAIL annul_on: ready/result rose, ready=%b result=%h want 0 0", ready_o, result_o); end
    do_div(1'b0, 32'd9, 32'd3);
  endtask

  task automatic test_start_annul_idle();
    bit rose;
    rose = 0;
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd10; opdata2_i = 32'd0; start_i = 1'b1; annul_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); start_i = 1'b0; annul_i = 1'b0;
    for (int c = 0; c < 36; c++) begin
      @(posedge clk); #1;
      if (ready_o !== 1'b0) rose = 1;
    end
    checks++;
    if (rose) begin errors++; $display("FAIL start_annul_idle: ready=%b want 0 (no accept)", ready_o); end
  endtask

  task automatic test_annul_end();
    int c;
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd50; opdata2_i = 32'd5; start_i = 1'b1;
    c = 0;
    do begin @(posedge clk); #1; c++; end while (ready_o !== 1'b1 && c < 40);
    checks++;
    if (result_o !== 64'h00000000_0000000A) begin
      errors++; $display("FAIL annul_end_result got %h want 000000000000000a", result_o);
    end
    @(negedge clk); annul_i = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      errors++; $display("FAIL annul_end ready=%b result=%h want 0 0", ready_o, result_o);
    end
    @(negedge clk); annul_i = 1'b0; start_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    bit rose;
    int c;
    rose = 0;
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'hFFFFFFFF; opdata2_i = 32'd3; start_i = 1'b1;
    @(posedge clk); #1;
    repeat (4) @(posedge clk);
    @(negedge clk); rst = 1'b1; start_i = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      errors++; $display("FAIL reset_mid ready=%b result=%h want 0 0", ready_o, result_o);
    end
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 36; k++) begin
      @(posedge clk); #1;
      if (ready_o !== 1'b0) rose = 1;
    end
    checks++;
    if (rose) begin errors++; $display("FAIL reset_mid_no_result: ready rose after reset"); end
    do_div(1'b0, 32'd1, 32'd1);
    // Reset while the result is being held.
    @(negedge clk);
    signed_div_i = 1'b1; opdata1_i = 32'd40; opdata2_i = 32'd0; start_i = 1'b1;
    c = 0;
    do begin @(posedge clk); #1; c++; end while (ready_o !== 1'b1 && c < 40);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      errors++; $display("FAIL reset_end ready=%b result=%h want 0 0", ready_o, result_o);
    end
    @(negedge clk); rst = 1'b0; start_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic s;
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 3) == 0) a = -a;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) b = -b;
      do_div(s, a, b);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_annul();
    test_start_annul_idle();
    test_annul_end();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
